// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared definitions for the counter sweep sequencer.
//   - WIDTH_DEF / SWEEP_W_DEF : default counter and sweep-count widths
//   - state_e                 : FSM state encoding, also exported on the debug port
package counter_sweep_ctrl_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int SWEEP_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// Control/status bundle between the surrounding control logic and the sweep sequencer.
// Handshake: there is no ready. A start request is accepted on a rising edge only when
// the sequencer is idle (busy=0, state=ST_IDLE) and stop is low. Starts issued while
// the sequencer is busy are dropped, not queued. stop is a level abort and overrides
// start. done and err are single-cycle pulses.
//
//   master (controller) drives : start, stop, lo, hi, n_sweeps
//   slave  (sequencer)  drives : count, p_dir, busy, done, err, state (debug)
interface counter_sweep_ctrl_if
  import counter_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SWEEP_W = SWEEP_W_DEF
);

  logic               start;
  logic               stop;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   hi;
  logic [SWEEP_W-1:0] n_sweeps;

  logic [WIDTH-1:0]   count;
  logic               p_dir;
  logic               busy;
  logic               done;
  logic               err;
  state_e             state;

  modport master (
    output start, stop, lo, hi, n_sweeps,
    input  count, p_dir, busy, done, err, state
  );

  modport slave (
    input  start, stop, lo, hi, n_sweeps,
    output count, p_dir, busy, done, err, state
  );

endinterface

// File: rtl/counter8b_updown_en.sv
// Up/down counter with enable and synchronous load.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   load       : load load_val (highest priority)
//   en         : step the count by one when high
//   up         : 1 = increment, 0 = decrement
//   load_val   : value loaded on load
//   count      : registered counter value
// The count saturates at both ends of its range instead of wrapping.
module counter8b_updown_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en) begin
      if (up) begin
        if (count_q != {WIDTH{1'b1}}) count_q <= count_q + WIDTH'(1);
      end else begin
        if (count_q != '0) count_q <= count_q - WIDTH'(1);
      end
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Triangle-wave sweep sequencer for the up/down counter.
// Sweeps count lo->hi->lo for n_sweeps sweeps (0 = until stop), then pulses done.
//   p_clk_in : clock
//   p_rst    : asynchronous active-low reset
//   bus      : slave side of counter_sweep_ctrl_if (requests in, count/status out,
//              FSM state on bus.state for debug)
// All status outputs are registered from the next-state decode so they line up with
// the state they describe.
module counter_sweep_ctrl
  import counter_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SWEEP_W = SWEEP_W_DEF
) (
  input  logic                  p_clk_in,
  input  logic                  p_rst,
  counter_sweep_ctrl_if.slave   bus
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [SWEEP_W-1:0] n_q, n_d;
  logic [SWEEP_W-1:0] sweep_q, sweep_d;
  logic               p_dir_q, busy_q, done_q, err_q;
  logic               p_dir_d, busy_d, done_d, err_d;

  logic               cnt_load, cnt_en, cnt_up;
  logic [WIDTH-1:0]   count;

  counter8b_updown_en #(.WIDTH(WIDTH)) u_cnt (
    .clk      (p_clk_in),
    .rst_n    (p_rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .up       (cnt_up),
    .load_val (bus.lo),
    .count    (count)
  );

  always_ff @(posedge p_clk_in or negedge p_rst) begin
    if (!p_rst) begin
      state_q <= ST_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      n_q     <= '0;
      sweep_q <= '0;
      p_dir_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      sweep_q <= sweep_d;
      p_dir_q <= p_dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    n_d      = n_q;
    sweep_d  = sweep_q;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_up   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // stop masks start even while idle
        if (bus.start && !bus.stop) begin
          if (bus.lo < bus.hi) begin
            lo_d     = bus.lo;
            hi_d     = bus.hi;
            n_d      = bus.n_sweeps;
            sweep_d  = '0;
            cnt_load = 1'b1;
            state_d  = ST_UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_UP: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (count < hi_q) begin
          cnt_en = 1'b1;
          cnt_up = 1'b1;
        end else begin
          // hi is shown for one cycle, then the count turns around immediately
          cnt_en  = 1'b1;
          cnt_up  = 1'b0;
          state_d = ST_DOWN;
        end
      end

      ST_DOWN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (count > lo_q) begin
          cnt_en = 1'b1;
          cnt_up = 1'b0;
        end else begin
          // bottom of a sweep; the counter sticks at all-ones in continuous mode
          if (sweep_q != {SWEEP_W{1'b1}}) sweep_d = sweep_q + SWEEP_W'(1);
          if ((n_q != '0) && (sweep_q == n_q - SWEEP_W'(1))) begin
            state_d = ST_DONE;
          end else begin
            cnt_en  = 1'b1;
            cnt_up  = 1'b1;
            state_d = ST_UP;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    p_dir_d = (state_d == ST_UP);
    busy_d  = (state_d == ST_UP) || (state_d == ST_DOWN);
    done_d  = (state_d == ST_DONE);
  end

  assign bus.count = count;
  assign bus.p_dir = p_dir_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
module tb_counter_sweep_ctrl;
  import counter_sweep_ctrl_pkg::*;

  logic p_clk_in = 1'b0;
  logic p_rst    = 1'b0;

  counter_sweep_ctrl_if bus ();

  counter_sweep_ctrl dut (
    .p_clk_in (p_clk_in),
    .p_rst    (p_rst),
    .bus      (bus)
  );

  // clock / reset
  always #5 p_clk_in = ~p_clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // step one edge, settle 1 time unit past it
  task automatic tick();
    @(posedge p_clk_in);
    #1;
  endtask

  // driver
  task automatic drive_start(input int lo_v, input int hi_v, input int n_v);
    bus.lo       = 8'(lo_v);
    bus.hi       = 8'(hi_v);
    bus.n_sweeps = 4'(n_v);
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic check_idle(input string tag, input int cnt_v);
    check({tag, "_count"}, 32'(bus.count), 32'(cnt_v));
    check({tag, "_dir"},   32'(bus.p_dir), 32'd0);
    check({tag, "_busy"},  32'(bus.busy),  32'd0);
    check({tag, "_done"},  32'(bus.done),  32'd0);
    check({tag, "_state"}, 32'(bus.state), 32'(ST_IDLE));
  endtask

  // lo=3, hi=5, N=1, hand-computed trace
  task automatic run_small(input string tag);
    logic [7:0] cnt_tab [5];
    logic       dir_tab [5];
    cnt_tab = '{8'd3, 8'd4, 8'd5, 8'd4, 8'd3};
    dir_tab = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    drive_start(3, 5, 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s_count%0d", tag, i), 32'(bus.count), 32'(cnt_tab[i]));
      check($sformatf("%s_dir%0d", tag, i),   32'(bus.p_dir), 32'(dir_tab[i]));
      check($sformatf("%s_busy%0d", tag, i),  32'(bus.busy),  32'd1);
      check($sformatf("%s_done%0d", tag, i),  32'(bus.done),  32'd0);
      tick();
    end
    // sixth edge after start
    check({tag, "_done_pulse"}, 32'(bus.done),  32'd1);
    check({tag, "_done_busy"},  32'(bus.busy),  32'd0);
    check({tag, "_done_count"}, 32'(bus.count), 32'd3);
    tick();
    check_idle({tag, "_after"}, 3);
  endtask

  // generic sweep: expected count stream built into exp_q
  task automatic run_sweep(input string tag, input int lo_v, input int hi_v, input int n_v);
    int done_seen;
    int idx;
    logic [7:0] exp_c;
    exp_q = {};
    for (int s = 0; s < n_v; s++) begin
      for (int v = (s == 0) ? lo_v : lo_v + 1; v <= hi_v; v++) exp_q.push_back(8'(v));
      for (int v = hi_v - 1; v >= lo_v; v--) exp_q.push_back(8'(v));
    end
    done_seen = 0;
    idx = 0;
    drive_start(lo_v, hi_v, n_v);
    while (exp_q.size() > 0) begin
      exp_c = exp_q.pop_front();
      check($sformatf("%s_count%0d", tag, idx), 32'(bus.count), 32'(exp_c));
      if (bus.done) done_seen++;
      idx++;
      tick();
    end
    if (bus.done) done_seen++;
    check({tag, "_end_count"}, 32'(bus.count), 32'(lo_v));
    check({tag, "_end_busy"},  32'(bus.busy),  32'd0);
    tick();
    if (bus.done) done_seen++;
    check({tag, "_done_pulses"}, 32'(done_seen), 32'd1);
    check_idle({tag, "_after"}, lo_v);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.lo       = '0;
    bus.hi       = '0;
    bus.n_sweeps = '0;

    // 1: reset and quiet idle
    #23;
    check_idle("rst", 0);
    check("rst_err", 32'(bus.err), 32'd0);
    p_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle($sformatf("idle%0d", i), 0);
    end

    // 2: short triangle
    run_small("s2");

    // 3: full range, two sweeps, no wrap
    run_sweep("s3", 0, 255, 2);

    // 4: bad bounds; count still lo=0 from scenario 3
    drive_start(7, 7, 1);
    check("s4_err",   32'(bus.err),   32'd1);
    check("s4_busy",  32'(bus.busy),  32'd0);
    check("s4_count", 32'(bus.count), 32'd0);
    tick();
    check("s4_err_clr", 32'(bus.err), 32'd0);
    check_idle("s4_after", 0);

    // start and stop together in idle: stop wins
    bus.stop = 1'b1;
    drive_start(1, 2, 1);
    bus.stop = 1'b0;
    check_idle("ss", 0);
    check("ss_err", 32'(bus.err), 32'd0);

    // 5: continuous mode aborted at 15
    drive_start(10, 20, 0);
    for (int i = 0; i < 5; i++) tick();
    check("s5_pre_count", 32'(bus.count), 32'd15);
    check("s5_pre_busy",  32'(bus.busy),  32'd1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_idle("s5_stop", 15);
    tick();
    check_idle("s5_hold", 15);

    // start ignored while busy
    drive_start(3, 5, 1);
    bus.lo    = 8'd50;
    bus.hi    = 8'd60;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_start_count", 32'(bus.count), 32'd4);
    tick();
    tick();
    check("busy_start_turn", 32'(bus.count), 32'd4);
    check("busy_start_dir",  32'(bus.p_dir), 32'd0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

    // 6: async reset mid-DOWN
    drive_start(3, 5, 1);
    tick();
    tick();
    tick();
    check("s6_pre_state", 32'(bus.state), 32'(ST_DOWN));
    #2;
    p_rst = 1'b0;
    #1;
    check_idle("s6_rst", 0);
    check("s6_rst_err", 32'(bus.err), 32'd0);
    #3;
    p_rst = 1'b1;
    tick();
    check_idle("s6_rel", 0);
    run_small("s6_again");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
